// File: rtl/div_op_sequencer_if.sv
// Request, divider and result signals for the divide front-end stage.
// slave is the sequencer's view; master is the view of whatever surrounds it.
interface div_op_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [TAG_W-1:0]     in_tag;
  logic                 div_start;
  logic [WIDTH-1:0]     div_a;
  logic [WIDTH-1:0]     div_b;
  logic [2*WIDTH-1:0]   div_quotient;
  logic [2*WIDTH-1:0]   div_remainder;
  logic                 div_done;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_quotient;
  logic [2*WIDTH-1:0]   out_remainder;
  logic [TAG_W-1:0]     out_tag;
  logic [1:0]           out_err;
  logic                 busy;

  modport slave (
    input  in_valid, in_a, in_b, in_tag,
    input  div_quotient, div_remainder, div_done,
    input  out_ready,
    output in_ready, div_start, div_a, div_b,
    output out_valid, out_quotient, out_remainder, out_tag, out_err, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_tag,
    output div_quotient, div_remainder, div_done,
    output out_ready,
    input  in_ready, div_start, div_a, div_b,
    input  out_valid, out_quotient, out_remainder, out_tag, out_err, busy
  );
endinterface

// File: rtl/div_op_sequencer.sv
// Front end for the non-restoring divider: takes a request, pulses start, waits
// for done (or times out), and holds the result until it is consumed.
module div_op_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  div_op_sequencer_if.slave bus,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [TAG_W-1:0]   tag_q;
  logic [2*WIDTH-1:0] q_q, r_q;
  logic [1:0]         err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept, div_zero, capture, expire;

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // valid never waits on ready, and ready is a pure function of state.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    expire   = 1'b0;
    div_zero = (bus.in_b == '0);
    case (state_q)
      S_IDLE: begin
        accept = bus.in_valid;
        if (accept) state_d = div_zero ? S_HOLD : S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // cnt_q == 0 is the first WAIT cycle, where done may still be left over
        capture = bus.div_done && (cnt_q != '0);
        expire  = !capture && (cnt_q == CNT_LAST);
        if (capture || expire) state_d = S_HOLD;
      end
      S_HOLD: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      err_q <= ERR_OK;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        a_q   <= bus.in_a;
        b_q   <= bus.in_b;
        tag_q <= bus.in_tag;
        if (div_zero) begin
          q_q   <= '0;
          r_q   <= '0;
          err_q <= ERR_DIV0;
        end
      end
      if (state_q == S_ISSUE) cnt_q <= '0;
      if (state_q == S_WAIT)  cnt_q <= cnt_q + 1'b1;
      if (capture) begin
        q_q   <= bus.div_quotient;
        r_q   <= bus.div_remainder;
        err_q <= ERR_OK;
      end
      if (expire) begin
        q_q   <= '0;
        r_q   <= '0;
        err_q <= ERR_TIMEOUT;
      end
    end
  end

  assign bus.in_ready      = (state_q == S_IDLE);
  assign bus.div_start     = (state_q == S_ISSUE);
  assign bus.div_a         = a_q;
  assign bus.div_b         = b_q;
  assign bus.out_valid     = (state_q == S_HOLD);
  assign bus.out_quotient  = q_q;
  assign bus.out_remainder = r_q;
  assign bus.out_tag       = tag_q;
  assign bus.out_err       = err_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign dbg_state         = state_q;

endmodule
